// File: rtl/alu_rs.sv
// alu_rs: reservation station feeding the LC-3b ALU.
// Holds up to ENTRIES decoded ALU ops and snoops the CDB so pending operands
// can be captured. Each cycle the lowest-index ready entry moves into a
// registered issue slot that drives the ALU.
// Optional macro ALURS_FAST_ISSUE_EN: a fully ready dispatching op may skip the
// station and load the issue slot directly when no entry is ready.
module alu_rs #(
    parameter int ENTRIES = 4,
    parameter int TAG_W   = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           dispatch_valid,
    output logic                           dispatch_ready,
    input  logic [2:0]                     dispatch_aluop,
    input  logic                           dispatch_a_pend,
    input  logic [TAG_W-1:0]               dispatch_a_tag,
    input  logic [15:0]                    dispatch_a_val,
    input  logic                           dispatch_b_pend,
    input  logic [TAG_W-1:0]               dispatch_b_tag,
    input  logic [15:0]                    dispatch_b_val,
    input  logic [TAG_W-1:0]               dispatch_dest,
    input  logic                           cdb_valid,
    input  logic [TAG_W-1:0]               cdb_tag,
    input  logic [15:0]                    cdb_data,
    output logic                           issue_valid,
    input  logic                           issue_ready,
    output logic [2:0]                     issue_aluop,
    output logic [15:0]                    issue_a,
    output logic [15:0]                    issue_b,
    output logic [TAG_W-1:0]               issue_dest,
    output logic [$clog2(ENTRIES+1)-1:0]   count
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int CNT_W = $clog2(ENTRIES+1);
    localparam logic [2:0] ALU_ADD = 3'd0;

    typedef struct packed {
        logic             busy;
        logic [2:0]       aluop;
        logic             a_pend;
        logic [TAG_W-1:0] a_tag;
        logic [15:0]      a_val;
        logic             b_pend;
        logic [TAG_W-1:0] b_tag;
        logic [15:0]      b_val;
        logic [TAG_W-1:0] dest;
    } entry_t;

    entry_t           ent_q [ENTRIES];
    entry_t           ent_d [ENTRIES];

    logic             issue_valid_q, issue_valid_d;
    logic [2:0]       issue_aluop_q, issue_aluop_d;
    logic [15:0]      issue_a_q, issue_a_d;
    logic [15:0]      issue_b_q, issue_b_d;
    logic [TAG_W-1:0] issue_dest_q, issue_dest_d;

    logic             rdy_found;
    logic [IDX_W-1:0] rdy_idx;
    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic             dispatch_fire;
    logic             issue_load;
    logic             bypass;
    logic             disp_a_pend;
    logic             disp_b_pend;
    logic [15:0]      disp_a_val;
    logic [15:0]      disp_b_val;
    logic [CNT_W-1:0] count_c;

    // Next-state logic: scan for ready/free entries, snoop the CDB, load the
    // issue slot, then allocate the dispatching op into the lowest free entry.
    always_comb begin
        ent_d         = ent_q;
        issue_valid_d = issue_valid_q;
        issue_aluop_d = issue_aluop_q;
        issue_a_d     = issue_a_q;
        issue_b_d     = issue_b_q;
        issue_dest_d  = issue_dest_q;
        rdy_found     = 1'b0;
        rdy_idx       = '0;
        free_found    = 1'b0;
        free_idx      = '0;
        bypass        = 1'b0;

        // Walking downward leaves the lowest matching index as the winner.
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (ent_q[i].busy && !ent_q[i].a_pend && !ent_q[i].b_pend) begin
                rdy_found = 1'b1;
                rdy_idx   = IDX_W'(i);
            end
            if (!ent_q[i].busy) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end

        dispatch_ready = free_found;
        dispatch_fire  = dispatch_valid && free_found;

        // A broadcast in the dispatch cycle must be captured here, since the
        // entry is not yet busy and so is invisible to the snoop below.
        disp_a_pend = dispatch_a_pend && !(cdb_valid && (dispatch_a_tag == cdb_tag));
        disp_b_pend = dispatch_b_pend && !(cdb_valid && (dispatch_b_tag == cdb_tag));
        disp_a_val  = dispatch_a_pend ? cdb_data : dispatch_a_val;
        disp_b_val  = dispatch_b_pend ? cdb_data : dispatch_b_val;

        for (int i = 0; i < ENTRIES; i++) begin
            if (ent_q[i].busy && cdb_valid) begin
                if (ent_q[i].a_pend && (ent_q[i].a_tag == cdb_tag)) begin
                    ent_d[i].a_pend = 1'b0;
                    ent_d[i].a_val  = cdb_data;
                end
                if (ent_q[i].b_pend && (ent_q[i].b_tag == cdb_tag)) begin
                    ent_d[i].b_pend = 1'b0;
                    ent_d[i].b_val  = cdb_data;
                end
            end
        end

        issue_load = !issue_valid_q || issue_ready;
        if (issue_load) begin
            if (rdy_found) begin
                issue_valid_d         = 1'b1;
                issue_aluop_d         = ent_q[rdy_idx].aluop;
                issue_a_d             = ent_q[rdy_idx].a_val;
                issue_b_d             = ent_q[rdy_idx].b_val;
                issue_dest_d          = ent_q[rdy_idx].dest;
                ent_d[rdy_idx].busy   = 1'b0;
            end
`ifdef ALURS_FAST_ISSUE_EN
            else if (dispatch_fire && !disp_a_pend && !disp_b_pend) begin
                bypass        = 1'b1;
                issue_valid_d = 1'b1;
                issue_aluop_d = dispatch_aluop;
                issue_a_d     = disp_a_val;
                issue_b_d     = disp_b_val;
                issue_dest_d  = dispatch_dest;
            end
`endif
            else begin
                issue_valid_d = 1'b0;
            end
        end

        // The free entry is never the one being issued or snooped, so this
        // write cannot collide with the updates above.
        if (dispatch_fire && !bypass) begin
            ent_d[free_idx].busy   = 1'b1;
            ent_d[free_idx].aluop  = dispatch_aluop;
            ent_d[free_idx].a_pend = disp_a_pend;
            ent_d[free_idx].a_tag  = dispatch_a_tag;
            ent_d[free_idx].a_val  = disp_a_val;
            ent_d[free_idx].b_pend = disp_b_pend;
            ent_d[free_idx].b_tag  = dispatch_b_tag;
            ent_d[free_idx].b_val  = disp_b_val;
            ent_d[free_idx].dest   = dispatch_dest;
        end
    end

    // Occupancy is simply the number of busy entries.
    always_comb begin
        count_c = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            count_c = count_c + CNT_W'(ent_q[i].busy);
        end
    end

    // State registers; flush squashes everything exactly like reset.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ent_q[i] <= '0;
            end
            issue_valid_q <= 1'b0;
            issue_aluop_q <= ALU_ADD;
            issue_a_q     <= '0;
            issue_b_q     <= '0;
            issue_dest_q  <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                ent_q[i] <= ent_d[i];
            end
            issue_valid_q <= issue_valid_d;
            issue_aluop_q <= issue_aluop_d;
            issue_a_q     <= issue_a_d;
            issue_b_q     <= issue_b_d;
            issue_dest_q  <= issue_dest_d;
        end
    end

    assign issue_valid = issue_valid_q;
    assign issue_aluop = issue_aluop_q;
    assign issue_a     = issue_a_q;
    assign issue_b     = issue_b_q;
    assign issue_dest  = issue_dest_q;
    assign count       = count_c;

endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- Reservation station sitting directly upstream of the ALU in the out-of-order LC-3b core.
- Accepts decoded ALU ops from dispatch, each with up to two operands that may still be pending on a ROB tag.
- Snoops the common data bus (CDB) to capture pending operands.
- Selects one fully-ready entry per cycle into a registered issue slot that drives the ALU inputs (aluop, a, b) plus the destination tag.

Parameters:
ENTRIES, 4, number of station entries (>=2)
TAG_W, 3, ROB tag width

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high; clears all entries and the issue slot
flush  in  1  synchronous squash (mispredict); same effect as reset
dispatch_valid  in  1  dispatch offers an op this cycle
dispatch_ready  out  1  a free entry exists
dispatch_aluop  in  lc3b_aluop  operation
dispatch_a_pend  in  1  operand A waits on dispatch_a_tag
dispatch_a_tag  in  TAG_W  producer tag for A
dispatch_a_val  in  16  A value when not pending
dispatch_b_pend  in  1  operand B waits on dispatch_b_tag
dispatch_b_tag  in  TAG_W  producer tag for B
dispatch_b_val  in  16  B value (register, imm, or shift amount) when not pending
dispatch_dest  in  TAG_W  destination ROB tag
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  TAG_W  broadcast tag
cdb_data  in  16  broadcast value
issue_valid  out  1  issue slot holds an op
issue_ready  in  1  ALU stage consumes the slot this cycle
issue_aluop  out  lc3b_aluop  op to ALU
issue_a  out  16  ALU input a
issue_b  out  16  ALU input b
issue_dest  out  TAG_W  tag the ALU result will broadcast under
count  out  $clog2(ENTRIES+1)  busy entries (excluding issue slot)

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset. No asynchronous state.
- Reset or flush at an edge:
  - all entry busy bits clear; issue_valid=0; count=0.
  - issue_aluop/a/b/dest reset to 0 (alu_add encoding for aluop).
  - Flush has priority over dispatch, CDB capture and issue in that cycle.
- Entry state: busy, aluop, a_pend/a_tag/a_val, b_pend/b_tag/b_val, dest.
- dispatch_ready = any entry not busy, computed from current state only; entries freed this cycle are not counted.
- Dispatch: when dispatch_valid && dispatch_ready, write the lowest-index free entry at the edge. dispatch_valid with dispatch_ready=0 is ignored; upstream holds.
- Dispatch-time capture: if cdb_valid, an operand is pending, and its tag == cdb_tag in the same cycle, store cdb_data with pend=0. This is mandatory; no broadcast may be missed.
- CDB snoop: each busy entry with a_pend (b_pend) and matching tag latches cdb_data and clears pend at the edge. Both operands may capture from one broadcast.
- Entry ready = busy && !a_pend && !b_pend, evaluated on registered state.
- Issue slot:
  - Loads when !issue_valid || issue_ready.
  - Takes the lowest-index ready entry; that entry is freed at the same edge.
  - If no entry is ready, issue_valid falls to 0 (after consume) or stays 0.
  - Outputs are stable while issue_valid && !issue_ready.
- Latency (no feature): dispatch with both operands ready at edge E0 → issue_valid at E1. An operand captured from the CDB at edge E → issue earliest at E+1.
- Simultaneous events:
  - Dispatch into an entry freed by issue in the same cycle is not allowed (see dispatch_ready).
  - Capture and issue never target the same entry (ready requires pend=0 already).
- Full: count==ENTRIES → dispatch_ready=0. Empty: count==0, issue_valid may still be 1.
- Operand b is passed verbatim; shift-amount masking is the ALU's concern.
- count updates at the edge: +1 on dispatch, -1 on issue load.

Optional Feature:
- Macro: ALURS_FAST_ISSUE_EN.
- Defined: when the issue slot loads this cycle, no station entry is ready, and a dispatching op has both operands ready (including via dispatch-time capture), the op bypasses the station straight into the issue slot. No entry is allocated, count is unchanged, and dispatch→issue_valid latency is the same edge (E0).
- Undefined: all ops pass through an entry; minimum latency is one cycle, as above.

Test Plan:
- Reset mid-operation: 3 busy entries, issue_valid=1, assert reset one cycle → count=0, issue_valid=0, dispatch_ready=1 next cycle.
- Dispatch alu_add a=0x0003 b=0x0004 both ready, issue_ready=1 → issue_valid at next edge with issue_a=0x0003, issue_b=0x0004, issue_dest=dispatch_dest. With ALURS_FAST_ISSUE_EN: same edge as dispatch.
- Dispatch alu_and with a pending tag 5; two cycles later cdb_valid tag 5 data 0x00FF → issue_a=0x00FF one edge after capture; no issue before the broadcast.
- Dispatch with b pending tag 2 while cdb_valid tag 2 data 0x0001 in the same cycle → entry stores b=0x0001 and issues normally; no hang.
- Fill all 4 entries ready, hold issue_ready=0 → dispatch_ready=0, count=4, issue outputs frozen. Release issue_ready → entries drain lowest index first, one per cycle.
- flush in the same cycle as dispatch and a CDB capture → count=0, issue_valid=0; the dispatched op does not appear.
